uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 27 ++
 rtl/rr_pick.sv | 38 +++
 rtl/uart_tx_arb.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART constants, plus the FSM state encoding and the
//           CR/LF byte constants used by the uart_tx_arb byte-stream arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmit framing
    localparam int c_UART_DATA_BITS = 8;
    localparam int c_UART_STOP_BITS = 1;

    // Line-ending bytes
    localparam logic [7:0] c_ASCII_CR = 8'h0D;
    localparam logic [7:0] c_ASCII_LF = 8'h0A;

    // Transmit arbiter state encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_arb_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker. Returns a one-hot grant for
//           the first set request found at or after i_ptr+1 (mod N).
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);

    int   w_idx;
    logic w_found;

    // Scan the requesters starting just after the pointer, wrapping once
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int off = 1; off <= N; off++) begin
            w_idx = int'(i_ptr) + off;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arb
// Brief   : Round-robin arbiter merging NREQ byte streams onto one UART
//           transmitter. An owner keeps the transmitter until the byte
//           flagged last has finished transmitting.
//           Build option UART_TX_ARB_CRLF_EN: an accepted LF is sent as
//           CR followed by LF under a single ready pulse.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
    parameter int NREQ  = 3,
    parameter int GUARD = 4
) (
    input  logic              clk24,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [NREQ-1:0]   grant_o,
    output logic [7:0]        o_uart_tx_data,
    output logic              o_uart_tx_wr,
    input  logic              i_uart_tx_busy
);

    import uart_pkg::*;

    localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_GW = $clog2(GUARD + 1);

    tx_arb_state_e   r_state;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_ready;
    logic [7:0]      r_data;
    logic            r_wr;
    logic            r_last;
    logic [c_PW-1:0] r_rr_ptr;
    logic [c_GW-1:0] r_guard_cnt;
`ifdef UART_TX_ARB_CRLF_EN
    logic            r_lf_pending;
`endif

    logic [NREQ-1:0] w_pick;
    logic            w_owner_valid;
    logic [7:0]      w_owner_data;
    logic            w_owner_last;
    logic [c_PW-1:0] w_owner_idx;
    logic            w_byte_done;

    // Binary index of a one-hot owner vector
    function automatic logic [c_PW-1:0] f_onehot_idx(input logic [NREQ-1:0] oh);
        logic [c_PW-1:0] idx;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (oh[k]) begin
                idx = c_PW'(k);
            end
        end
        return idx;
    endfunction

    rr_pick #(
        .N  (NREQ),
        .PW (c_PW)
    ) u_rr_pick (
        .i_req   (req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick)
    );

    // Route the current owner's byte, last flag and valid
    always_comb begin
        w_owner_data = '0;
        w_owner_last = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_grant[k]) begin
                w_owner_data = req_data_i[8*k +: 8];
                w_owner_last = req_last_i[k];
            end
        end
    end

    assign w_owner_valid = |(r_grant & req_valid_i);
    assign w_owner_idx   = f_onehot_idx(r_grant);

    // A byte is finished once busy drops, or the guard expires with busy never seen
    assign w_byte_done = ((r_state == ST_WAIT_BUSY) && !i_uart_tx_busy &&
                          (r_guard_cnt == c_GW'(GUARD - 1))) ||
                         ((r_state == ST_WAIT_DONE) && !i_uart_tx_busy);

    // Arbitration / transmit FSM with registered outputs
    always_ff @(posedge clk24) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_ready      <= '0;
            r_data       <= 8'h00;
            r_wr         <= 1'b0;
            r_last       <= 1'b0;
            r_rr_ptr     <= c_PW'(NREQ - 1);
            r_guard_cnt  <= '0;
`ifdef UART_TX_ARB_CRLF_EN
            r_lf_pending <= 1'b0;
`endif
        end else begin
            r_ready <= '0;
            r_wr    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_grant == '0) begin
                        r_grant <= w_pick;
                    end else if (w_owner_valid) begin
                        r_ready <= r_grant;
                        r_last  <= w_owner_last;
                        r_wr    <= 1'b1;
                        r_state <= ST_ISSUE;
`ifdef UART_TX_ARB_CRLF_EN
                        if (w_owner_data == c_ASCII_LF) begin
                            r_data       <= c_ASCII_CR;
                            r_lf_pending <= 1'b1;
                        end else begin
                            r_data <= w_owner_data;
                        end
`else
                        r_data <= w_owner_data;
`endif
                    end
                end
                ST_ISSUE: begin
                    r_guard_cnt <= '0;
                    r_state     <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (i_uart_tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + c_GW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    r_state <= ST_WAIT_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_byte_done) begin
`ifdef UART_TX_ARB_CRLF_EN
                if (r_lf_pending) begin
                    r_lf_pending <= 1'b0;
                    r_data       <= c_ASCII_LF;
                    r_wr         <= 1'b1;
                    r_state      <= ST_ISSUE;
                end else
`endif
                begin
                    r_state <= ST_IDLE;
                    if (r_last) begin
                        r_grant  <= '0;
                        r_rr_ptr <= w_owner_idx;
                    end
                end
            end
        end
    end

    assign req_ready_o    = r_ready;
    assign grant_o        = r_grant;
    assign o_uart_tx_data = r_data;
    assign o_uart_tx_wr   = r_wr;

endmodule : uart_tx_arb
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_arb
// Brief   : Directed self-checking bench for uart_tx_arb (NREQ=3, GUARD=4)
//           with requester stream models and a busy-pulse transmitter model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_arb;

    logic        clk24 = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid_i = '0;
    logic [23:0] req_data_i  = '0;
    logic [2:0]  req_last_i  = '0;
    logic        i_uart_tx_busy = 1'b0;
    wire  [2:0]  req_ready_o;
    wire  [2:0]  grant_o;
    wire  [7:0]  o_uart_tx_data;
    wire         o_uart_tx_wr;

    uart_tx_arb #(.NREQ(3), .GUARD(4)) dut (
        .clk24          (clk24),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_last_i     (req_last_i),
        .req_ready_o    (req_ready_o),
        .grant_o        (grant_o),
        .o_uart_tx_data (o_uart_tx_data),
        .o_uart_tx_wr   (o_uart_tx_wr),
        .i_uart_tx_busy (i_uart_tx_busy)
    );

    always #21 clk24 = ~clk24;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // requester stream models
    logic [7:0] s_data [0:2][0:15];
    logic       s_last [0:2][0:15];
    int         s_n [0:2];
    int         s_p [0:2];

    // transmitter model
    int busy_en   = 1;
    int busy_len  = 10;
    int busy_left = 0;
    int tx_pend   = 0;

    logic [7:0] tx_log [$];
    int         rdy_log [$];
    int         wr_cyc [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        s_data[k][s_n[k]] = d;
        s_last[k][s_n[k]] = l;
        s_n[k]++;
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < 3; k++) begin
            if (s_p[k] < s_n[k]) begin
                req_valid_i[k]       = 1'b1;
                req_data_i[8*k +: 8] = s_data[k][s_p[k]];
                req_last_i[k]        = s_last[k][s_p[k]];
            end else begin
                req_valid_i[k] = 1'b0;
            end
        end
    endtask

    function automatic bit drained();
        return (s_p[0] >= s_n[0]) && (s_p[1] >= s_n[1]) && (s_p[2] >= s_n[2]);
    endfunction

    // One clock: observe outputs just after the edge, advance models, drive inputs
    task automatic tick();
        @(posedge clk24);
        #1;
        cyc++;
        if (tx_pend != 0) begin
            i_uart_tx_busy = 1'b1;
            busy_left      = busy_len;
            tx_pend        = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) i_uart_tx_busy = 1'b0;
        end
        if (o_uart_tx_wr) begin
            tx_log.push_back(o_uart_tx_data);
            wr_cyc.push_back(cyc);
            if (busy_en != 0) tx_pend = 1;
        end
        if (req_ready_o != 3'b000) begin
            chk("ready_is_owner", {29'd0, req_ready_o & ~grant_o}, 32'd0);
            chk("ready_onehot", $countones(req_ready_o), 32'd1);
            for (int k = 0; k < 3; k++) begin
                if (req_ready_o[k]) begin
                    rdy_log.push_back(k);
                    s_p[k]++;
                end
            end
        end
        drive_reqs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_uart_tx_busy = 1'b0;
        busy_left = 0;
        tx_pend   = 0;
        busy_en   = 1;
        for (int k = 0; k < 3; k++) begin
            s_n[k] = 0;
            s_p[k] = 0;
        end
        drive_reqs();
        tick();
        tick();
        tx_log.delete();
        rdy_log.delete();
        wr_cyc.delete();
        rst_n = 1'b1;
    endtask

    task automatic run_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!(drained() && grant_o == 3'b000 && !i_uart_tx_busy && tx_pend == 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({tag, "_timeout"}, 32'd1, 32'd0);
        tick();
        tick();
    endtask

    int mark_tx;
    int mark_rdy;
    int n;

    initial begin
        for (int k = 0; k < 3; k++) begin
            s_n[k] = 0;
            s_p[k] = 0;
        end

        // ---------------- reset values ----------------
        do_reset();
        rst_n = 1'b0;
        tick();
        chk("rst_grant", {29'd0, grant_o}, 32'd0);
        chk("rst_ready", {29'd0, req_ready_o}, 32'd0);
        chk("rst_wr", {31'd0, o_uart_tx_wr}, 32'd0);
        chk("rst_data", {24'd0, o_uart_tx_data}, 32'h00);
        rst_n = 1'b1;

        // ---------------- single byte 41, busy for 10 cycles ----------------
        do_reset();
        push(0, 8'h41, 1'b1);
        drive_reqs();
        tick();
        chk("t1_grant", {29'd0, grant_o}, 32'd1);
        chk("t1_ready_early", {29'd0, req_ready_o}, 32'd0);
        tick();
        chk("t1_ready", {29'd0, req_ready_o}, 32'd1);
        chk("t1_wr", {31'd0, o_uart_tx_wr}, 32'd1);
        chk("t1_data", {24'd0, o_uart_tx_data}, 32'h41);
        n = 0;
        while (!i_uart_tx_busy && n < 20) begin tick(); n++; end
        while (i_uart_tx_busy && n < 40) begin tick(); n++; end
        if (n >= 40) chk("t1_busy_timeout", 32'd1, 32'd0);
        chk("t1_grant_held", {29'd0, grant_o}, 32'd1);
        tick();
        chk("t1_grant_released", {29'd0, grant_o}, 32'd0);
        run_idle("t1", 100);
        chk("t1_nbytes", tx_log.size(), 32'd1);
        chk("t1_byte0", {24'd0, tx_log[0]}, 32'h41);
        chk("t1_nready", rdy_log.size(), 32'd1);
        chk("t1_data_hold", {24'd0, o_uart_tx_data}, 32'h41);

        // ---------------- message lock: AB then 5A ----------------
        do_reset();
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b1);
        push(1, 8'h5A, 1'b1);
        drive_reqs();
        run_idle("lock", 300);
        chk("lock_nbytes", tx_log.size(), 32'd3);
        chk("lock_b0", {24'd0, tx_log[0]}, 32'h41);
        chk("lock_b1", {24'd0, tx_log[1]}, 32'h42);
        chk("lock_b2", {24'd0, tx_log[2]}, 32'h5A);
        chk("lock_r0", rdy_log[0], 32'd0);
        chk("lock_r1", rdy_log[1], 32'd0);
        chk("lock_r2", rdy_log[2], 32'd1);

        // ---------------- fairness: 4 single-byte messages each ----------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                push(k, 8'(8'h30 + 16*k + i), 1'b1);
            end
        end
        drive_reqs();
        run_idle("fair", 1000);
        chk("fair_nready", rdy_log.size(), 32'd12);
        chk("fair_nbytes", tx_log.size(), 32'd12);
        for (int m = 0; m < 12; m++) begin
            chk("fair_order", rdy_log[m], 32'(m % 3));
            chk("fair_byte", {24'd0, tx_log[m]}, 32'(8'h30 + 16*(m % 3) + m / 3));
        end

        // ---------------- guard: busy never asserted ----------------
        do_reset();
        busy_en = 0;
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b1);
        drive_reqs();
        run_idle("guard", 200);
        chk("guard_nbytes", tx_log.size(), 32'd2);
        chk("guard_b0", {24'd0, tx_log[0]}, 32'h11);
        chk("guard_b1", {24'd0, tx_log[1]}, 32'h22);
        chk("guard_spacing", wr_cyc[1] - wr_cyc[0], 32'd6);
        chk("guard_released", {29'd0, grant_o}, 32'd0);

        // ---------------- reset while waiting for busy to fall ----------------
        do_reset();
        push(0, 8'h61, 1'b0);
        push(0, 8'h62, 1'b1);
        push(1, 8'h71, 1'b1);
        drive_reqs();
        n = 0;
        while (!i_uart_tx_busy && n < 20) begin tick(); n++; end
        if (n >= 20) chk("mrst_busy_timeout", 32'd1, 32'd0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_grant", {29'd0, grant_o}, 32'd0);
        chk("mrst_ready", {29'd0, req_ready_o}, 32'd0);
        chk("mrst_wr", {31'd0, o_uart_tx_wr}, 32'd0);
        chk("mrst_data", {24'd0, o_uart_tx_data}, 32'h00);
        rst_n = 1'b1;
        mark_tx  = tx_log.size();
        mark_rdy = rdy_log.size();
        chk("mrst_pre_bytes", mark_tx, 32'd1);
        run_idle("mrst", 300);
        chk("mrst_nbytes", tx_log.size(), 32'(mark_tx + 2));
        chk("mrst_b0", {24'd0, tx_log[mark_tx]}, 32'h62);
        chk("mrst_b1", {24'd0, tx_log[mark_tx + 1]}, 32'h71);
        chk("mrst_r0", rdy_log[mark_rdy], 32'd0);
        chk("mrst_r1", rdy_log[mark_rdy + 1], 32'd1);

        // ---------------- line feed handling ----------------
        do_reset();
        push(0, 8'h0A, 1'b1);
        drive_reqs();
        run_idle("lf", 200);
        chk("lf_nready", rdy_log.size(), 32'd1);
`ifdef UART_TX_ARB_CRLF_EN
        chk("lf_nbytes", tx_log.size(), 32'd2);
        chk("lf_b0", {24'd0, tx_log[0]}, 32'h0D);
        chk("lf_b1", {24'd0, tx_log[1]}, 32'h0A);
`else
        chk("lf_nbytes", tx_log.size(), 32'd1);
        chk("lf_b0", {24'd0, tx_log[0]}, 32'h0A);
`endif
        chk("lf_released", {29'd0, grant_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_uart_tx_arb
`default_nettype wire
